irq_timer: RTL



---
 rtl/cpu_params_pkg.sv | 15 +
 rtl/mtime_prescaler.sv | 31 +++
 rtl/irq_timer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters: I/O bus widths, timer register map and timer FSM encoding.
package cpu_params_pkg;

  localparam int PC_SZ = 32;
  localparam int RSZ   = 32;

  localparam logic [PC_SZ-1:0] MSIP_Base_Addr     = 32'h0200_0000;
  localparam logic [PC_SZ-1:0] MTIMECMP_Base_Addr = 32'h0200_4000;
  localparam logic [PC_SZ-1:0] MTIME_Base_Addr    = 32'h0200_BFF8;

  localparam int TIMER_CLK_DIV = 1;

  typedef enum logic {TMR_IDLE, TMR_RESP} tmr_state_t;

endpackage

// File: rtl/mtime_prescaler.sv
// Divides the core clock down to the mtime increment rate; o_tick is high
// on the last clock of each CLK_DIV-clock period.
module mtime_prescaler
  import cpu_params_pkg::*;
#(
  parameter int CLK_DIV = TIMER_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] r_div_cnt;
  logic        w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// Machine timer / software interrupt block on the internal I/O port.
//   state    | meaning
//   TMR_IDLE | waiting for io_req; access is performed on the accept edge
//   TMR_RESP | io_ack (with rd_data/fault) is high for this one cycle
module irq_timer
  import cpu_params_pkg::*;
#(
  parameter int               CLK_DIV       = TIMER_CLK_DIV,
  parameter logic [PC_SZ-1:0] MSIP_ADDR     = MSIP_Base_Addr,
  parameter logic [PC_SZ-1:0] MTIME_ADDR    = MTIME_Base_Addr,
  parameter logic [PC_SZ-1:0] MTIMECMP_ADDR = MTIMECMP_Base_Addr
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             io_req,
  input  logic             io_wr,
  input  logic [PC_SZ-1:0] io_addr,
  input  logic [RSZ-1:0]   io_wr_data,
  output logic             io_ack,
  output logic [RSZ-1:0]   io_rd_data,
  output logic             io_fault,
  output logic             msip_out,
  output logic             mtip_out
);

  localparam logic [PC_SZ-1:0] MTIME_HI_ADDR    = MTIME_ADDR + PC_SZ'(4);
  localparam logic [PC_SZ-1:0] MTIMECMP_HI_ADDR = MTIMECMP_ADDR + PC_SZ'(4);

  tmr_state_t r_state, w_state_next;

  logic           w_tick;
  logic           w_accept;
  logic           w_aligned;
  logic           w_sel_msip, w_sel_mt_lo, w_sel_mt_hi, w_sel_cmp_lo, w_sel_cmp_hi;
  logic           w_fault;
  logic [RSZ-1:0] w_rd_mux;

  logic [63:0]    r_mtime;
  logic [63:0]    r_mtimecmp;
  logic           r_msip;
  logic           r_mtip;
  logic           r_ack;
  logic           r_fault;
  logic [RSZ-1:0] r_rd_data;

  mtime_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .i_clk   (clk_in),
    .i_reset (reset_in),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= TMR_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      TMR_IDLE: begin
        if (io_req) begin
          w_accept     = 1'b1;
          w_state_next = TMR_RESP;
        end
      end
      TMR_RESP: w_state_next = TMR_IDLE;
      default:  w_state_next = TMR_IDLE;
    endcase
  end

  always_comb begin
    w_aligned    = (io_addr[1:0] == 2'b00);
    w_sel_msip   = w_aligned && (io_addr == MSIP_ADDR);
    w_sel_mt_lo  = w_aligned && (io_addr == MTIME_ADDR);
    w_sel_mt_hi  = w_aligned && (io_addr == MTIME_HI_ADDR);
    w_sel_cmp_lo = w_aligned && (io_addr == MTIMECMP_ADDR);
    w_sel_cmp_hi = w_aligned && (io_addr == MTIMECMP_HI_ADDR);
    w_fault      = !(w_sel_msip || w_sel_mt_lo || w_sel_mt_hi || w_sel_cmp_lo || w_sel_cmp_hi);
    w_rd_mux     = '0;
    if (w_sel_msip)        w_rd_mux = {31'b0, r_msip};
    else if (w_sel_mt_lo)  w_rd_mux = r_mtime[31:0];
    else if (w_sel_mt_hi)  w_rd_mux = r_mtime[63:32];
    else if (w_sel_cmp_lo) w_rd_mux = r_mtimecmp[31:0];
    else if (w_sel_cmp_hi) w_rd_mux = r_mtimecmp[63:32];
  end

  // A store to either mtime half wins over the tick; the other half is untouched.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_mtip     <= 1'b0;
      r_ack      <= 1'b0;
      r_fault    <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ack     <= w_accept;
      r_fault   <= w_accept && w_fault;
      r_rd_data <= (w_accept && !io_wr) ? w_rd_mux : '0;
      r_mtip    <= (r_mtime >= r_mtimecmp);

      if (w_accept && io_wr && w_sel_msip)   r_msip             <= io_wr_data[0];
      if (w_accept && io_wr && w_sel_cmp_lo) r_mtimecmp[31:0]   <= io_wr_data;
      if (w_accept && io_wr && w_sel_cmp_hi) r_mtimecmp[63:32]  <= io_wr_data;

      if (w_accept && io_wr && w_sel_mt_lo)      r_mtime[31:0]  <= io_wr_data;
      else if (w_accept && io_wr && w_sel_mt_hi) r_mtime[63:32] <= io_wr_data;
      else if (w_tick)                           r_mtime        <= r_mtime + 64'd1;
    end
  end

  assign io_ack     = r_ack;
  assign io_fault   = r_fault;
  assign io_rd_data = r_rd_data;
  assign msip_out   = r_msip;
  assign mtip_out   = r_mtip;

endmodule
